// File: rtl/plc_corr_table_if.sv
// Correlation-table bus: tuple insert, lookup request and prediction response.
// The bench drives through master; the table sits on slave.
interface plc_corr_table_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAY_WIDTH  = 4
);
    logic [2*ADDR_WIDTH-1:0] add_addr_tuple;
    logic [2*WAY_WIDTH-1:0]  add_way_tuple;
    logic                    add_flag;
    logic                    clear;
    logic                    lookup_valid;
    logic [ADDR_WIDTH-1:0]   lookup_addr;
    logic                    pred_valid;
    logic                    pred_hit;
    logic [ADDR_WIDTH-1:0]   pred_addr;
    logic [WAY_WIDTH-1:0]    pred_way;
    logic [2:0]              fifo_count;
    logic [7:0]              drop_cnt;

    modport master (
        output add_addr_tuple, add_way_tuple, add_flag, clear,
        output lookup_valid, lookup_addr,
        input  pred_valid, pred_hit, pred_addr, pred_way,
        input  fifo_count, drop_cnt
    );

    modport slave (
        input  add_addr_tuple, add_way_tuple, add_flag, clear,
        input  lookup_valid, lookup_addr,
        output pred_valid, pred_hit, pred_addr, pred_way,
        output fifo_count, drop_cnt
    );
endinterface

// File: rtl/plc_corr_table.sv
// Direct-mapped address-correlation table fed by a 4-deep insert FIFO.
// Lookups win the table port; the FIFO drains only on lookup-free cycles.
module plc_corr_table #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAY_WIDTH  = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    plc_corr_table_if.slave   bus
);
    localparam int DEPTH = 1 << IDX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - IDX_WIDTH;

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [TAG_W-1:0]      tag_q [DEPTH];
    logic [TAG_W-1:0]      tag_d [DEPTH];
    logic [ADDR_WIDTH-1:0] nxt_q [DEPTH];
    logic [ADDR_WIDTH-1:0] nxt_d [DEPTH];
    logic [WAY_WIDTH-1:0]  way_q [DEPTH];
    logic [WAY_WIDTH-1:0]  way_d [DEPTH];

    logic [ADDR_WIDTH-1:0] fx_q [4];
    logic [ADDR_WIDTH-1:0] fx_d [4];
    logic [ADDR_WIDTH-1:0] fn_q [4];
    logic [ADDR_WIDTH-1:0] fn_d [4];
    logic [WAY_WIDTH-1:0]  fw_q [4];
    logic [WAY_WIDTH-1:0]  fw_d [4];

    logic [1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            drop_q, drop_d;
    logic                  pv_q, pv_d, ph_q, ph_d;
    logic [ADDR_WIDTH-1:0] pa_q, pa_d;
    logic [WAY_WIDTH-1:0]  pw_q, pw_d;

    logic                  drain, push_req, push, hit;
    logic [ADDR_WIDTH-1:0] x_addr, n_addr, hd_addr;
    logic [WAY_WIDTH-1:0]  n_way;
    logic [IDX_WIDTH-1:0]  lk_idx, hd_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  unused_way;

    assign x_addr     = bus.add_addr_tuple[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign n_addr     = bus.add_addr_tuple[ADDR_WIDTH-1:0];
    assign n_way      = bus.add_way_tuple[WAY_WIDTH-1:0];
    assign unused_way = ^bus.add_way_tuple[2*WAY_WIDTH-1:WAY_WIDTH];
    assign lk_idx     = bus.lookup_addr[IDX_WIDTH-1:0];
    assign lk_tag     = bus.lookup_addr[ADDR_WIDTH-1:IDX_WIDTH];
    assign hd_addr    = fx_q[rd_q];
    assign hd_idx     = hd_addr[IDX_WIDTH-1:0];
    assign hit        = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        nxt_d    = nxt_q;
        way_d    = way_q;
        fx_d     = fx_q;
        fn_d     = fn_q;
        fw_d     = fw_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        pv_d     = 1'b0;
        ph_d     = ph_q;
        pa_d     = pa_q;
        pw_d     = pw_q;
        drain    = (cnt_q != 3'd0) && !bus.lookup_valid && !bus.clear;
        push_req = bus.add_flag && !bus.clear;
        // A full FIFO still accepts when the head leaves this same cycle
        push     = push_req && ((cnt_q != 3'd4) || drain);

        if (bus.clear) begin
            vld_d = '0;
            rd_d  = 2'd0;
            wr_d  = 2'd0;
            cnt_d = 3'd0;
        end else begin
            if (bus.lookup_valid) begin
                pv_d = 1'b1;
                ph_d = hit;
                pa_d = hit ? nxt_q[lk_idx] : '0;
                pw_d = hit ? way_q[lk_idx] : '0;
            end
            if (drain) begin
                vld_d[hd_idx] = 1'b1;
                tag_d[hd_idx] = hd_addr[ADDR_WIDTH-1:IDX_WIDTH];
                nxt_d[hd_idx] = fn_q[rd_q];
                way_d[hd_idx] = fw_q[rd_q];
                rd_d          = rd_q + 2'd1;
            end
            if (push) begin
                fx_d[wr_q] = x_addr;
                fn_d[wr_q] = n_addr;
                fw_d[wr_q] = n_way;
                wr_d       = wr_q + 2'd1;
            end
            if (push_req && !push && (drop_q != 8'hff))
                drop_d = drop_q + 8'd1;
            cnt_d = cnt_q + {2'b00, push} - {2'b00, drain};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            rd_q   <= 2'd0;
            wr_q   <= 2'd0;
            cnt_q  <= 3'd0;
            drop_q <= 8'd0;
            pv_q   <= 1'b0;
            ph_q   <= 1'b0;
            pa_q   <= '0;
            pw_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            pv_q   <= pv_d;
            ph_q   <= ph_d;
            pa_q   <= pa_d;
            pw_q   <= pw_d;
        end
    end

    // Payload storage is qualified by valid bits and pointers, so it needs no reset
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        nxt_q <= nxt_d;
        way_q <= way_d;
        fx_q  <= fx_d;
        fn_q  <= fn_d;
        fw_q  <= fw_d;
    end

    assign bus.pred_valid = pv_q;
    assign bus.pred_hit   = ph_q;
    assign bus.pred_addr  = pa_q;
    assign bus.pred_way   = pw_q;
    assign bus.fifo_count = cnt_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_plc_corr_table.sv
// Bench for plc_corr_table: directed scenarios plus randomized traffic
// checked every cycle against a queue/array reference model.
module tb_plc_corr_table;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    plc_corr_table_if bus ();

    plc_corr_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] n;
        logic [3:0] w;
    } tup_t;

    tup_t       mq[$];
    bit         mv   [16];
    logic [7:0] mkey [16];
    logic [7:0] mnx  [16];
    logic [3:0] mwy  [16];
    int         mdrop;
    bit         mpv, mph;
    logic [7:0] mpa;
    logic [3:0] mpw;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: table keyed by whole trigger address
    always @(posedge clk or posedge rst) begin : mdl
        bit   drn;
        int   ix;
        tup_t h;
        tup_t t;
        if (rst) begin
            for (int i = 0; i < 16; i++) mv[i] = 1'b0;
            mq.delete();
            mdrop = 0;
            mpv = 0; mph = 0; mpa = '0; mpw = '0;
        end else if (bus.clear) begin
            for (int i = 0; i < 16; i++) mv[i] = 1'b0;
            mq.delete();
            mpv = 0;
        end else begin
            drn = (mq.size() > 0) && !bus.lookup_valid;
            mpv = bus.lookup_valid;
            if (bus.lookup_valid) begin
                ix  = int'(bus.lookup_addr % 16);
                mph = mv[ix] && (mkey[ix] == bus.lookup_addr);
                mpa = mph ? mnx[ix] : 8'h00;
                mpw = mph ? mwy[ix] : 4'h0;
            end
            if (drn) begin
                h  = mq.pop_front();
                ix = int'(h.x % 16);
                mv[ix] = 1'b1; mkey[ix] = h.x; mnx[ix] = h.n; mwy[ix] = h.w;
            end
            if (bus.add_flag) begin
                if (mq.size() < 4) begin
                    t.x = bus.add_addr_tuple[15:8];
                    t.n = bus.add_addr_tuple[7:0];
                    t.w = bus.add_way_tuple[3:0];
                    mq.push_back(t);
                end else if (mdrop < 255) begin
                    mdrop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pred_valid", 32'(bus.pred_valid), 32'(mpv));
        chk("pred_hit",   32'(bus.pred_hit),   32'(mph));
        chk("pred_addr",  32'(bus.pred_addr),  32'(mpa));
        chk("pred_way",   32'(bus.pred_way),   32'(mpw));
        chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
        chk("drop_cnt",   32'(bus.drop_cnt),   32'(mdrop));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.add_flag     = 1'b0;
        bus.clear        = 1'b0;
        bus.lookup_valid = 1'b0;
    endtask

    task automatic set_add(input logic [7:0] x, input logic [7:0] n,
                           input logic [3:0] w);
        bus.add_flag       = 1'b1;
        bus.add_addr_tuple = {x, n};
        bus.add_way_tuple  = {4'h0, w};
    endtask

    task automatic look(input logic [7:0] a, input bit hit,
                        input logic [7:0] na, input logic [3:0] nw,
                        input string nm);
        idle();
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = a;
        step();
        chk({nm, ".v"}, 32'(bus.pred_valid), 32'd1);
        chk({nm, ".h"}, 32'(bus.pred_hit), 32'(hit));
        chk({nm, ".a"}, 32'(bus.pred_addr), 32'(na));
        chk({nm, ".w"}, 32'(bus.pred_way), 32'(nw));
        bus.lookup_valid = 1'b0;
    endtask

    initial begin
        bus.add_addr_tuple = '0;
        bus.add_way_tuple  = '0;
        bus.lookup_addr    = '0;
        idle();
        #1 rst = 1'b1;
        #1;
        chk("rst.pv",  32'(bus.pred_valid), 32'd0);
        chk("rst.cnt", 32'(bus.fifo_count), 32'd0);
        chk("rst.drp", 32'(bus.drop_cnt),   32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Insert then lookup
        set_add(8'h35, 8'h36, 4'h7);
        bus.add_way_tuple = 8'h27;
        step();
        chk("ins.cnt", 32'(bus.fifo_count), 32'd1);
        idle();
        step();
        step();
        chk("ins.drain", 32'(bus.fifo_count), 32'd0);
        look(8'h35, 1'b1, 8'h36, 4'h7, "hit35");
        step();
        chk("idle.pv", 32'(bus.pred_valid), 32'd0);
        chk("idle.hold", 32'(bus.pred_addr), 32'h36);

        // Alias miss and overwrite
        look(8'h45, 1'b0, 8'h00, 4'h0, "alias45");
        set_add(8'h45, 8'h10, 4'h3);
        step();
        idle();
        step();
        look(8'h35, 1'b0, 8'h00, 4'h0, "evict35");
        look(8'h45, 1'b1, 8'h10, 4'h3, "hit45");

        // Overflow under continuous lookup
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 8'h00;
        for (int i = 0; i < 6; i++) begin
            set_add(8'h60 + 8'(i), 8'h70 + 8'(i), 4'(i));
            step();
        end
        chk("ovf.cnt", 32'(bus.fifo_count), 32'd4);
        chk("ovf.drp", 32'(bus.drop_cnt),   32'd2);
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("ovf.empty", 32'(bus.fifo_count), 32'd0);
        for (int i = 0; i < 4; i++)
            look(8'h60 + 8'(i), 1'b1, 8'h70 + 8'(i), 4'(i), "ovf.hit");
        look(8'h64, 1'b0, 8'h00, 4'h0, "ovf.lost4");
        look(8'h65, 1'b0, 8'h00, 4'h0, "ovf.lost5");

        // Full FIFO with simultaneous drain and push
        bus.lookup_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_add(8'h80 + 8'(i), 8'h11, 4'h1);
            step();
        end
        bus.lookup_valid = 1'b0;
        set_add(8'h84, 8'h22, 4'h2);
        step();
        chk("full.cnt", 32'(bus.fifo_count), 32'd4);
        chk("full.drp", 32'(bus.drop_cnt),   32'd2);
        idle();
        for (int i = 0; i < 5; i++) step();
        look(8'h84, 1'b1, 8'h22, 4'h2, "full.hit84");

        // Clear with pending tuples and a same-cycle add
        bus.lookup_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_add(8'h90 + 8'(i), 8'h33, 4'h3);
            step();
        end
        chk("clr.pre", 32'(bus.fifo_count), 32'd3);
        bus.clear = 1'b1;
        set_add(8'h9f, 8'h44, 4'h4);
        step();
        chk("clr.cnt", 32'(bus.fifo_count), 32'd0);
        chk("clr.pv",  32'(bus.pred_valid), 32'd0);
        chk("clr.drp", 32'(bus.drop_cnt),   32'd2);
        idle();
        step();
        look(8'h60, 1'b0, 8'h00, 4'h0, "clr.m60");
        look(8'h84, 1'b0, 8'h00, 4'h0, "clr.m84");
        look(8'h90, 1'b0, 8'h00, 4'h0, "clr.m90");

        // Async reset in the middle of a drain
        set_add(8'h60, 8'h5a, 4'h9);
        step();
        idle();
        step();
        look(8'h60, 1'b1, 8'h5a, 4'h9, "pre.rst");
        bus.lookup_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_add(8'ha0 + 8'(i), 8'h01, 4'h1);
            step();
        end
        idle();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst.pv",  32'(bus.pred_valid), 32'd0);
        chk("arst.ph",  32'(bus.pred_hit),   32'd0);
        chk("arst.pa",  32'(bus.pred_addr),  32'd0);
        chk("arst.pw",  32'(bus.pred_way),   32'd0);
        chk("arst.cnt", 32'(bus.fifo_count), 32'd0);
        chk("arst.drp", 32'(bus.drop_cnt),   32'd0);
        step();
        rst = 1'b0;
        step();
        look(8'h60, 1'b0, 8'h00, 4'h0, "arst.m60");
        look(8'ha0, 1'b0, 8'h00, 4'h0, "arst.ma0");

        // Drop counter saturation
        bus.lookup_valid = 1'b1;
        set_add(8'hc0, 8'hc1, 4'h5);
        for (int i = 0; i < 304; i++) step();
        chk("sat.drp", 32'(bus.drop_cnt),   32'd255);
        chk("sat.cnt", 32'(bus.fifo_count), 32'd4);
        step();
        chk("sat.hold", 32'(bus.drop_cnt),  32'd255);
        idle();
        bus.clear = 1'b1;
        step();
        chk("sat.clr", 32'(bus.drop_cnt),   32'd255);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Randomized traffic over a small address space for frequent hits
        for (int i = 0; i < 2500; i++) begin
            bus.add_flag       = ($urandom_range(0, 99) < 50);
            bus.add_addr_tuple = {8'($urandom_range(0, 63)), 8'($urandom)};
            bus.add_way_tuple  = 8'($urandom);
            bus.lookup_valid   = ($urandom_range(0, 99) < 35);
            bus.lookup_addr    = 8'($urandom_range(0, 63));
            bus.clear          = ($urandom_range(0, 99) < 2);
            step();
        end
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
